vnu3_f0_lut_array: RTL and testbench
====================================

Name: vnu3_f0_lut_array

Overview:
- Parametrised next-generation first stage (F0) of the degree-3 IB variable-node update.
- Handles VNU_NUM VNUs per instance. Each VNU makes two symmetric IB-LUT lookups: (ch_llr, c2v0) and (ch_llr, c2v2).
- Forwards c2v1/c2v2 and the frame offset, delay-matched, to the F1 stage.
- Adds two things the earlier block lacked: an on-block sequential LUT loader with per-frame ready tracking, and a valid/error qualifier on every result.

Parameters:
- QUAN_SIZE, 3, message/LLR width in bits.
- VNU_NUM, 4, number of VNUs served; must be ≥1.
- MULTI_FRAME_NUM, 2, number of LUT frames (tables) held; must be a power of 2, ≥2.
- FRM_W, $clog2(MULTI_FRAME_NUM), frame-index width (derived; do not override).
- LUT_ADDR, 2*QUAN_SIZE, table address width per frame (derived).

Ports:
- read_clk  in  1  sole clock; all reads, writes and state use it.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input message set valid this cycle.
- read_addr_offset  in  FRM_W  frame used for this input set.
- c2v0_bus, c2v1_bus, c2v2_bus, ch_llr_bus  in  VNU_NUM*QUAN_SIZE each  packed per VNU; VNU i occupies [i*QUAN_SIZE +: QUAN_SIZE].
- wr_start  in  1  begin loading a frame.
- wr_frame  in  FRM_W  frame to load; sampled on wr_start.
- wr_valid  in  1  wr_data word valid.
- wr_data  in  QUAN_SIZE  LUT word, streamed in ascending address order.
- out_valid  out  1  results valid.
- out_err  out  1  the frame read was not ready when the input was accepted.
- read_addr_offset_out  out  FRM_W  delay-matched frame offset.
- tport0_bus, tport1_bus  out  VNU_NUM*QUAN_SIZE  lookup results.
- tran_en0_bus, tran_en1_bus  out  VNU_NUM  transpose flags.
- c2v1_out_bus, c2v2_out_bus  out  VNU_NUM*QUAN_SIZE  delay-matched c2v1/c2v2.
- frame_ready  out  MULTI_FRAME_NUM  per-frame table-loaded bits.
- load_busy  out  1  loader in LOAD state.
- load_done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Addressing, lookup 0 of VNU i: a=ch_llr, b=c2v0.
  - tran_en0 = (a<b), unsigned compare.
  - Address = {frame, max(a,b), min(a,b)}.
- Lookup 1 is identical with b=c2v2.
- Table content is addressed by the canonical (max, min) pair only, so f(a,b)=f(b,a).
- Read pipeline latency is exactly 2 cycles:
  - Cycle 0: inputs are registered together with the canonical address, transpose flags, frame, in_valid, and err = ~frame_ready[frame].
  - Cycle 1: synchronous RAM read.
  - Cycle 2: out_valid and all other outputs appear together.
- c2v1/c2v2 and read_addr_offset_out pass through the same 2 register stages.
- Full throughput: one input set per cycle, no stall.
- With in_valid=0, out_valid=0 two cycles later. Data outputs then hold don't-care values; the bench must not check them.
- Storage: MULTI_FRAME_NUM*2^LUT_ADDR words of QUAN_SIZE bits, logically shared by all VNUs. The implementation may replicate RAMs to provide the 2*VNU_NUM read ports; all copies receive the same writes.
- Loader FSM, IDLE:
  - wr_start → LOAD. Latch wr_frame, clear counter to 0, clear frame_ready[wr_frame].
  - wr_valid is ignored.
- Loader FSM, LOAD:
  - On wr_valid: write wr_data at {frame, counter} and increment the counter.
  - On the write with counter = 2^LUT_ADDR-1: set frame_ready[frame], pulse load_done the next cycle, return to IDLE.
  - Counter wraps to 0; no write occurs beyond the end.
- wr_start during LOAD restarts the load:
  - The abandoned frame stays not-ready.
  - The new frame is latched, its ready bit is cleared, and the counter restarts at 0.
  - If wr_valid is also asserted that cycle, it is ignored.
- Read/write same address in the same cycle: read-first, so the read returns the old word.
- A read of a frame under load is allowed; it returns mixed data with out_err=1.
- Reset: all pipeline valids, out_valid, out_err, load_done, load_busy, frame_ready and counters clear to 0; FSM goes to IDLE.
  - RAM contents are not cleared.
  - Registered data outputs reset to 0.
  - Reset mid-load abandons the load.
  - Inputs in flight during reset are dropped; no out_valid follows.
- Outputs in cycles 1–2 after reset release are 0.

Test Plan:
- Load frame 0 with word[{hi,lo}] = (hi+lo)&7 (QUAN_SIZE=3, 64 words). Expect load_busy high for 64 wr_valid cycles, load_done pulse, frame_ready=2'b01.
- Frame 0 loaded; send in_valid with VNU0 ch_llr=2, c2v0=5, c2v2=1. Two cycles later expect out_valid=1, tport0=7 with tran_en0=1, tport1=3 with tran_en1=0, out_err=0.
- Read frame 1 before it is loaded → out_valid=1, out_err=1. Load frame 1 with all 6s, read again → tport0=6, out_err=0, read_addr_offset_out=1.
- 10 back-to-back in_valid sets with changing c2v1/c2v2 → 10 consecutive out_valid cycles, each c2v1_out/c2v2_out matching its own input set 2 cycles earlier.
- wr_start frame 1 after 20 words, then wr_start frame 0 → frame_ready[1]=0; frame 0 completes after 64 more words; load_done pulses once.
- Assert rst mid-load and with in_valid in flight → frame_ready=0, load_busy=0, no out_valid in the following 3 cycles.

Source files
------------

// File: rtl/vnu3_f0_lut_array_if.sv
// Bus bundle for the F0 stage of the degree-3 IB variable-node update.
// The master side drives messages and LUT load words; the slave side returns lookups and loader status.
interface vnu3_f0_lut_array_if #(
  parameter int QUAN_SIZE       = 3,
  parameter int VNU_NUM         = 4,
  parameter int MULTI_FRAME_NUM = 2
);
  localparam int FRM_W = $clog2(MULTI_FRAME_NUM);
  localparam int BW    = VNU_NUM * QUAN_SIZE;

  // Read side: in_valid qualifies one message set per cycle and is never stalled.
  // out_valid follows exactly two cycles later; out_err marks a set that read a frame not yet loaded.
  logic                       in_valid;
  logic [FRM_W-1:0]           read_addr_offset;
  logic [BW-1:0]              c2v0_bus;
  logic [BW-1:0]              c2v1_bus;
  logic [BW-1:0]              c2v2_bus;
  logic [BW-1:0]              ch_llr_bus;
  logic                       wr_start;
  logic [FRM_W-1:0]           wr_frame;
  logic                       wr_valid;
  logic [QUAN_SIZE-1:0]       wr_data;
  logic                       out_valid;
  logic                       out_err;
  logic [FRM_W-1:0]           read_addr_offset_out;
  logic [BW-1:0]              tport0_bus;
  logic [BW-1:0]              tport1_bus;
  logic [VNU_NUM-1:0]         tran_en0_bus;
  logic [VNU_NUM-1:0]         tran_en1_bus;
  logic [BW-1:0]              c2v1_out_bus;
  logic [BW-1:0]              c2v2_out_bus;
  logic [MULTI_FRAME_NUM-1:0] frame_ready;
  logic                       load_busy;
  logic                       load_done;
  logic                       load_state;

  modport master (
    output in_valid, read_addr_offset, c2v0_bus, c2v1_bus, c2v2_bus, ch_llr_bus,
    output wr_start, wr_frame, wr_valid, wr_data,
    input  out_valid, out_err, read_addr_offset_out, tport0_bus, tport1_bus,
    input  tran_en0_bus, tran_en1_bus, c2v1_out_bus, c2v2_out_bus,
    input  frame_ready, load_busy, load_done, load_state
  );

  modport slave (
    input  in_valid, read_addr_offset, c2v0_bus, c2v1_bus, c2v2_bus, ch_llr_bus,
    input  wr_start, wr_frame, wr_valid, wr_data,
    output out_valid, out_err, read_addr_offset_out, tport0_bus, tport1_bus,
    output tran_en0_bus, tran_en1_bus, c2v1_out_bus, c2v2_out_bus,
    output frame_ready, load_busy, load_done, load_state
  );
endinterface

// File: rtl/vnu3_f0_lut_array.sv
// F0 stage of the degree-3 IB VNU: two symmetric LUT lookups per VNU with a 2-cycle read pipeline,
// plus an on-block sequential table loader that tracks which frames hold a complete table.
module vnu3_f0_lut_array #(
  parameter int QUAN_SIZE       = 3,
  parameter int VNU_NUM         = 4,
  parameter int MULTI_FRAME_NUM = 2,
  localparam int FRM_W    = $clog2(MULTI_FRAME_NUM),
  localparam int LUT_ADDR = 2 * QUAN_SIZE
) (
  input logic                read_clk,
  input logic                rst,
  vnu3_f0_lut_array_if.slave bus
);
  localparam int AW    = FRM_W + LUT_ADDR;
  localparam int DEPTH = MULTI_FRAME_NUM << LUT_ADDR;
  localparam int BW    = VNU_NUM * QUAN_SIZE;

  typedef enum logic {S_IDLE = 1'b0, S_LOAD = 1'b1} ld_state_t;

  ld_state_t                  state, state_nx;
  logic [FRM_W-1:0]           ld_frame;
  logic [LUT_ADDR-1:0]        ld_cnt;
  logic                       ld_last;
  logic                       wr_en;
  logic                       load_busy_c;
  logic [MULTI_FRAME_NUM-1:0] frame_ready;
  logic                       load_done_q;

  logic [QUAN_SIZE-1:0] mem [DEPTH];

  logic [AW-1:0]      addr0_c [VNU_NUM];
  logic [AW-1:0]      addr1_c [VNU_NUM];
  logic [VNU_NUM-1:0] tr0_c, tr1_c;

  logic               s1_valid, s1_err;
  logic [FRM_W-1:0]   s1_frame;
  logic [AW-1:0]      s1_addr0 [VNU_NUM];
  logic [AW-1:0]      s1_addr1 [VNU_NUM];
  logic [VNU_NUM-1:0] s1_tr0, s1_tr1;
  logic [BW-1:0]      s1_c2v1, s1_c2v2;

  logic               out_valid_q, out_err_q;
  logic [FRM_W-1:0]   off_q;
  logic [BW-1:0]      t0_q, t1_q, c2v1_q, c2v2_q;
  logic [VNU_NUM-1:0] tr0_q, tr1_q;

  // Tables store only the (max, min) half, so each operand pair is swapped into canonical order.
  for (genvar i = 0; i < VNU_NUM; i++) begin : g_canon
    logic [QUAN_SIZE-1:0] a, b0, b2;
    assign a          = bus.ch_llr_bus[i*QUAN_SIZE +: QUAN_SIZE];
    assign b0         = bus.c2v0_bus[i*QUAN_SIZE +: QUAN_SIZE];
    assign b2         = bus.c2v2_bus[i*QUAN_SIZE +: QUAN_SIZE];
    assign tr0_c[i]   = (a < b0);
    assign tr1_c[i]   = (a < b2);
    assign addr0_c[i] = tr0_c[i] ? {bus.read_addr_offset, b0, a} : {bus.read_addr_offset, a, b0};
    assign addr1_c[i] = tr1_c[i] ? {bus.read_addr_offset, b2, a} : {bus.read_addr_offset, a, b2};
  end

  always_ff @(posedge read_clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_frame <= '0;
      s1_tr0   <= '0;
      s1_tr1   <= '0;
      s1_c2v1  <= '0;
      s1_c2v2  <= '0;
      for (int i = 0; i < VNU_NUM; i++) begin
        s1_addr0[i] <= '0;
        s1_addr1[i] <= '0;
      end
    end else begin
      s1_valid <= bus.in_valid;
      s1_err   <= bus.in_valid & ~frame_ready[bus.read_addr_offset];
      if (bus.in_valid) begin
        s1_frame <= bus.read_addr_offset;
        s1_addr0 <= addr0_c;
        s1_addr1 <= addr1_c;
        s1_tr0   <= tr0_c;
        s1_tr1   <= tr1_c;
        s1_c2v1  <= bus.c2v1_bus;
        s1_c2v2  <= bus.c2v2_bus;
      end
    end
  end

  // Data registers only advance on valid sets, so they stay at zero after reset until real data arrives.
  always_ff @(posedge read_clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      off_q       <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      tr0_q       <= '0;
      tr1_q       <= '0;
      c2v1_q      <= '0;
      c2v2_q      <= '0;
    end else begin
      out_valid_q <= s1_valid;
      out_err_q   <= s1_err;
      if (s1_valid) begin
        off_q  <= s1_frame;
        tr0_q  <= s1_tr0;
        tr1_q  <= s1_tr1;
        c2v1_q <= s1_c2v1;
        c2v2_q <= s1_c2v2;
        for (int i = 0; i < VNU_NUM; i++) begin
          t0_q[i*QUAN_SIZE +: QUAN_SIZE] <= mem[s1_addr0[i]];
          t1_q[i*QUAN_SIZE +: QUAN_SIZE] <= mem[s1_addr1[i]];
        end
      end
    end
  end

  // Nonblocking write alongside the registered reads gives read-first behaviour on a collision.
  always_ff @(posedge read_clk) begin
    if (wr_en) mem[{ld_frame, ld_cnt}] <= bus.wr_data;
  end

  assign ld_last = (ld_cnt == {LUT_ADDR{1'b1}});

  always_ff @(posedge read_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.wr_start) state_nx = S_LOAD;
      S_LOAD:  if (!bus.wr_start && bus.wr_valid && ld_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    load_busy_c = (state == S_LOAD);
    wr_en       = (state == S_LOAD) && bus.wr_valid && !bus.wr_start;
  end

  // A restart abandons the current frame; its ready bit was already cleared when that load began.
  always_ff @(posedge read_clk) begin
    if (rst) begin
      ld_frame    <= '0;
      ld_cnt      <= '0;
      frame_ready <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      if (bus.wr_start) begin
        ld_frame              <= bus.wr_frame;
        ld_cnt                <= '0;
        frame_ready[bus.wr_frame] <= 1'b0;
      end else if (wr_en) begin
        ld_cnt <= ld_cnt + 1'b1;
        if (ld_last) begin
          frame_ready[ld_frame] <= 1'b1;
          load_done_q           <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid            = out_valid_q;
  assign bus.out_err              = out_err_q;
  assign bus.read_addr_offset_out = off_q;
  assign bus.tport0_bus           = t0_q;
  assign bus.tport1_bus           = t1_q;
  assign bus.tran_en0_bus         = tr0_q;
  assign bus.tran_en1_bus         = tr1_q;
  assign bus.c2v1_out_bus         = c2v1_q;
  assign bus.c2v2_out_bus         = c2v2_q;
  assign bus.frame_ready          = frame_ready;
  assign bus.load_busy            = load_busy_c;
  assign bus.load_done            = load_done_q;
  assign bus.load_state           = (state == S_LOAD);
endmodule

// File: tb/tb_vnu3_f0_lut_array.sv
// Bench for vnu3_f0_lut_array: directed vector table plus randomized traffic against a table-level model.
module tb_vnu3_f0_lut_array;
  localparam int QS = 3;
  localparam int VN = 4;
  localparam int MF = 2;
  localparam int FW = $clog2(MF);
  localparam int W  = VN * QS;
  localparam int NW = 1 << (2 * QS);

  logic read_clk = 1'b0;
  logic rst;

  vnu3_f0_lut_array_if #(.QUAN_SIZE(QS), .VNU_NUM(VN), .MULTI_FRAME_NUM(MF)) bus ();

  vnu3_f0_lut_array #(.QUAN_SIZE(QS), .VNU_NUM(VN), .MULTI_FRAME_NUM(MF)) dut (
    .read_clk (read_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 read_clk = ~read_clk;

  typedef struct {
    bit             valid;
    bit             zero;
    bit             err;
    logic [FW-1:0]  frame;
    logic [W-1:0]   ch, c0, c1, c2;
  } req_t;

  typedef struct {
    bit             valid;
    bit             zero;
    bit             err;
    logic [FW-1:0]  frame;
    logic [W-1:0]   t0, t1, m0, m1, c1, c2;
    logic [VN-1:0]  tr0, tr1;
  } res_t;

  typedef struct {
    logic [QS-1:0] ch, c0, c2;
    logic [FW-1:0] fr;
    logic [QS-1:0] t0;
    bit            tr0;
    logic [QS-1:0] t1;
    bit            tr1;
    bit            err;
    bit            dchk;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int done_cnt, valid_cnt, busy_cnt;

  // Model state: table contents as written, which words are known, ready bits and the load in progress.
  logic [QS-1:0] ref_mem   [MF][NW];
  bit            ref_known [MF][NW];
  bit [MF-1:0]   ref_ready;
  bit            ld_active;
  int            ld_frame, ld_cnt;
  bit            exp_done;
  req_t          exp_q[$];
  vec_t          vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input int fr, input int a, input int b,
                                 output logic [QS-1:0] v, output bit k);
    int hi, lo;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    v  = ref_mem[fr][hi * (1 << QS) + lo];
    k  = ref_known[fr][hi * (1 << QS) + lo];
  endfunction

  function automatic res_t resolve(input req_t q);
    res_t r;
    logic [QS-1:0] v;
    bit k;
    int a, b0, b2;
    r = '{default: '0};
    r.valid = q.valid; r.zero = q.zero; r.err = q.err; r.frame = q.frame;
    r.c1 = q.c1; r.c2 = q.c2;
    for (int i = 0; i < VN; i++) begin
      a  = int'(q.ch[i*QS +: QS]);
      b0 = int'(q.c0[i*QS +: QS]);
      b2 = int'(q.c2[i*QS +: QS]);
      r.tr0[i] = (a < b0);
      r.tr1[i] = (a < b2);
      lookup(int'(q.frame), a, b0, v, k);
      r.t0[i*QS +: QS] = v;
      r.m0[i*QS +: QS] = k ? {QS{1'b1}} : {QS{1'b0}};
      lookup(int'(q.frame), a, b2, v, k);
      r.t1[i*QS +: QS] = v;
      r.m1[i*QS +: QS] = k ? {QS{1'b1}} : {QS{1'b0}};
    end
    return r;
  endfunction

  task automatic model_loader();
    exp_done = 1'b0;
    if (rst) begin
      ld_active = 1'b0;
      ld_cnt    = 0;
      ref_ready = '0;
    end else if (bus.wr_start) begin
      ld_active           = 1'b1;
      ld_frame            = int'(bus.wr_frame);
      ld_cnt              = 0;
      ref_ready[ld_frame] = 1'b0;
    end else if (ld_active && bus.wr_valid) begin
      ref_mem[ld_frame][ld_cnt]   = bus.wr_data;
      ref_known[ld_frame][ld_cnt] = 1'b1;
      ld_cnt++;
      if (ld_cnt == NW) begin
        ref_ready[ld_frame] = 1'b1;
        ld_active           = 1'b0;
        ld_cnt              = 0;
        exp_done            = 1'b1;
      end
    end
  endtask

  task automatic check_out(input res_t r);
    chk("out_valid", bus.out_valid, r.valid);
    if (r.zero) begin
      chk("rst_err", bus.out_err, 0);
      chk("rst_offset", bus.read_addr_offset_out, 0);
      chk("rst_tport0", bus.tport0_bus, 0);
      chk("rst_tport1", bus.tport1_bus, 0);
      chk("rst_tran", {bus.tran_en1_bus, bus.tran_en0_bus}, 0);
      chk("rst_c2v", {bus.c2v2_out_bus, bus.c2v1_out_bus}, 0);
    end else if (r.valid) begin
      chk("out_err", bus.out_err, r.err);
      chk("offset_out", bus.read_addr_offset_out, r.frame);
      chk("tran_en0", bus.tran_en0_bus, r.tr0);
      chk("tran_en1", bus.tran_en1_bus, r.tr1);
      chk("c2v1_out", bus.c2v1_out_bus, r.c1);
      chk("c2v2_out", bus.c2v2_out_bus, r.c2);
      if (r.m0 != 0) chk("tport0", bus.tport0_bus & r.m0, r.t0 & r.m0);
      if (r.m1 != 0) chk("tport1", bus.tport1_bus & r.m1, r.t1 & r.m1);
    end
  endtask

  // One clock: resolve the set due this cycle, queue the set being driven, advance the model, sample.
  task automatic step();
    req_t q;
    res_t r;
    bit   have;
    have = 1'b0;
    if (exp_q.size() != 0) begin
      r    = resolve(exp_q.pop_front());
      have = 1'b1;
    end
    if (rst && have) begin
      r.valid = 1'b0;
      r.zero  = 1'b1;
    end
    q.valid = bus.in_valid && !rst;
    q.zero  = rst;
    q.err   = !ref_ready[bus.read_addr_offset];
    q.frame = bus.read_addr_offset;
    q.ch    = bus.ch_llr_bus;
    q.c0    = bus.c2v0_bus;
    q.c1    = bus.c2v1_bus;
    q.c2    = bus.c2v2_bus;
    exp_q.push_back(q);
    model_loader();
    @(posedge read_clk);
    @(negedge read_clk);
    if (have) check_out(r);
    chk("load_busy", bus.load_busy, ld_active);
    chk("frame_ready", bus.frame_ready, ref_ready);
    chk("load_done", bus.load_done, exp_done);
    if (bus.load_done) done_cnt++;
    if (bus.out_valid) valid_cnt++;
    if (bus.load_busy) busy_cnt++;
  endtask

  task automatic drive_read(input bit v, input int fr);
    bus.in_valid         = v;
    bus.read_addr_offset = FW'(fr);
    bus.ch_llr_bus       = W'($urandom);
    bus.c2v0_bus         = W'($urandom);
    bus.c2v1_bus         = W'($urandom);
    bus.c2v2_bus         = W'($urandom);
  endtask

  // mode 0: (hi+lo)&7, mode 1: all 6s, mode 2: random words.
  task automatic load_frame(input int fr, input int mode, input int nwords, input bit reads, input bit wv_start);
    bus.wr_start = 1'b1;
    bus.wr_frame = FW'(fr);
    bus.wr_valid = wv_start;
    bus.wr_data  = QS'($urandom);
    drive_read(reads && $urandom_range(0, 1) == 1, $urandom_range(0, MF - 1));
    step();
    bus.wr_start = 1'b0;
    for (int n = 0; n < nwords; n++) begin
      bus.wr_valid = 1'b1;
      case (mode)
        0:       bus.wr_data = QS'(((n >> QS) + (n % (1 << QS))) % (1 << QS));
        1:       bus.wr_data = QS'(6);
        default: bus.wr_data = QS'($urandom);
      endcase
      drive_read(reads && $urandom_range(0, 1) == 1, $urandom_range(0, MF - 1));
      step();
    end
    bus.wr_valid = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    drive_read(1'b1, int'(v.fr));
    bus.ch_llr_bus[QS-1:0] = v.ch;
    bus.c2v0_bus[QS-1:0]   = v.c0;
    bus.c2v2_bus[QS-1:0]   = v.c2;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("vec_valid", bus.out_valid, 1);
    chk("vec_err", bus.out_err, v.err);
    chk("vec_offset", bus.read_addr_offset_out, v.fr);
    if (v.dchk) begin
      chk("vec_tport0", bus.tport0_bus[QS-1:0], v.t0);
      chk("vec_tran0", bus.tran_en0_bus[0], v.tr0);
      chk("vec_tport1", bus.tport1_bus[QS-1:0], v.t1);
      chk("vec_tran1", bus.tran_en1_bus[0], v.tr1);
    end
  endtask

  initial begin
    vt[0] = '{3'd2, 3'd5, 3'd1, 1'b0, 3'd7, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
    vt[1] = '{3'd0, 3'd0, 3'd7, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b1};
    vt[2] = '{3'd7, 3'd7, 3'd7, 1'b0, 3'd6, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1};
    vt[3] = '{3'd3, 3'd4, 3'd4, 1'b0, 3'd7, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1};
    vt[4] = '{3'd6, 3'd1, 3'd2, 1'b0, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{3'd1, 3'd2, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{3'd3, 3'd5, 3'd0, 1'b1, 3'd6, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    bus.wr_start = 1'b0; bus.wr_frame = '0; bus.wr_valid = 1'b0; bus.wr_data = '0;
    drive_read(1'b0, 0);
    ld_active = 1'b0; ld_frame = 0; ld_cnt = 0; ref_ready = '0;
    done_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    busy_cnt = 0; done_cnt = 0;
    load_frame(0, 0, NW, 1'b0, 1'b0);
    step();
    chk("load0_busy_cycles", busy_cnt, NW);
    chk("load0_done_pulses", done_cnt, 1);
    chk("load0_ready", bus.frame_ready, 2'b01);

    for (int i = 0; i < 6; i++) apply_vec(vt[i]);

    load_frame(1, 1, NW, 1'b0, 1'b0);
    apply_vec(vt[6]);

    valid_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      drive_read(1'b1, $urandom_range(0, MF - 1));
      step();
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    chk("burst_valid_count", valid_cnt, 10);

    done_cnt = 0;
    load_frame(1, 2, 20, 1'b1, 1'b0);
    load_frame(0, 2, NW, 1'b1, 1'b1);
    chk("restart_ready1", bus.frame_ready[1], 0);
    step();
    chk("restart_done_pulses", done_cnt, 1);
    chk("restart_ready", bus.frame_ready, 2'b01);

    load_frame(1, 2, 10, 1'b0, 1'b0);
    drive_read(1'b1, 0);
    step();
    rst = 1'b1;
    drive_read(1'b1, 1);
    bus.wr_valid = 1'b1;
    step();
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    bus.in_valid = 1'b0;
    valid_cnt = 0;
    repeat (3) step();
    chk("rst_no_valid", valid_cnt, 0);
    chk("rst_ready_clear", bus.frame_ready, 0);
    chk("rst_busy_clear", bus.load_busy, 0);

    for (int n = 0; n < 400; n++) begin
      drive_read($urandom_range(0, 3) != 0, $urandom_range(0, MF - 1));
      bus.wr_start = ld_active ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 29) == 0);
      bus.wr_frame = FW'($urandom_range(0, MF - 1));
      bus.wr_valid = $urandom_range(0, 3) != 0;
      bus.wr_data  = QS'($urandom);
      step();
    end
    bus.wr_start = 1'b0;
    bus.wr_valid = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
